branch_predictor: RTL and testbench

Parametrised dynamic branch predictor and resolution unit for the RISC-V pipeline. It holds a table of 2-bit saturating counters to predict conditional branches (opcode 7'b1100011) at fetch. At EX it compares the carried prediction with the actual outcome and generates the PC redirect and the flush. It trains the table and counts mispredictions; non-branch instructions pass the upstream flush through unchanged.

---
 rtl/branch_predictor.sv | 69 ++++++
 tb/tb_branch_predictor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch predictor with EX-stage resolution.
//   clk, rst_n (async, active-low)
//   if_pc, if_inst -> if_pred, if_idx          fetch lookup (combinational)
//   ex_valid, ex_inst, ex_idx, ex_pred, ex_taken, flush_in
//                  -> redirect, redirect_tgt, flush   EX resolution (combinational)
//   mispredict_cnt                              saturating mispredict count
//   Define BP_GSHARE_EN to XOR a global history register into the index.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic             if_pred,
    output logic [IDX_W-1:0] if_idx,
    input  logic             ex_valid,
    input  logic [31:0]      ex_inst,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic             ex_pred,
    input  logic             ex_taken,
    input  logic [1:0]       flush_in,
    output logic             redirect,
    output logic             redirect_tgt,
    output logic [1:0]       flush,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam logic [6:0] BR = 7'b1100011;

    logic [1:0] cnt_tab [ENTRIES];
    logic       resolve, mis;
    logic [1:0] cur;
    logic       unused_bits;

    assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], if_inst[31:7], ex_inst[31:7]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    assign if_idx = if_pc[IDX_W+1:2] ^ ghr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr <= '0;
        else if (resolve) ghr <= {ghr[IDX_W-2:0], ex_taken};
    end
`else
    assign if_idx = if_pc[IDX_W+1:2];
`endif

    assign if_pred      = (if_inst[6:0] == BR) && cnt_tab[if_idx][1];
    assign resolve      = ex_valid && (ex_inst[6:0] == BR);
    assign mis          = resolve && (ex_pred != ex_taken);
    assign redirect     = mis;
    assign redirect_tgt = mis && ex_taken;
    assign flush        = resolve ? (mis ? 2'b11 : 2'b00) : flush_in;
    assign cur          = cnt_tab[ex_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt_tab[i] <= 2'b01;
            mispredict_cnt <= '0;
        end else begin
            if (resolve)
                cnt_tab[ex_idx] <= ex_taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                                            : ((cur == 2'b00) ? cur : cur - 2'b01);
            if (mis && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench with a behavioural predictor model.
module tb_branch_predictor;
    localparam int N = 64;
    localparam int IW = 6;
    localparam int CW = 4;
    localparam logic [31:0] BEQ = 32'h0000_0063;
    localparam logic [31:0] ADD = 32'h0000_0033;

    logic          clk = 0;
    logic          rst_n = 1;
    logic [31:0]   if_pc = 0, if_inst = 0, ex_inst = 0;
    logic          if_pred;
    logic [IW-1:0] if_idx, ex_idx = 0;
    logic          ex_valid = 0, ex_pred = 0, ex_taken = 0;
    logic [1:0]    flush_in = 0, flush;
    logic          redirect, redirect_tgt;
    logic [CW-1:0] mispredict_cnt;

    int total = 0, bad = 0;

    int m_cnt [N];
    int m_mis;
    int m_ghr;

    branch_predictor #(.ENTRIES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_inst(if_inst),
        .if_pred(if_pred), .if_idx(if_idx), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .ex_idx(ex_idx), .ex_pred(ex_pred), .ex_taken(ex_taken), .flush_in(flush_in),
        .redirect(redirect), .redirect_tgt(redirect_tgt), .flush(flush),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return ((pc / 4) % N) ^ m_ghr;
`else
        return (pc / 4) % N;
`endif
    endfunction

    function automatic bit is_br(input logic [31:0] inst);
        return inst[6:0] == 7'b1100011;
    endfunction

    // Model: plain integer counters 0..3, prediction is "count >= 2".
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 1;
            m_mis = 0;
            m_ghr = 0;
        end else if (ex_valid && is_br(ex_inst)) begin
            if (ex_taken) m_cnt[ex_idx] = (m_cnt[ex_idx] < 3) ? m_cnt[ex_idx] + 1 : 3;
            else m_cnt[ex_idx] = (m_cnt[ex_idx] > 0) ? m_cnt[ex_idx] - 1 : 0;
            if (ex_pred != ex_taken) m_mis = (m_mis < (1 << CW) - 1) ? m_mis + 1 : m_mis;
            m_ghr = ((m_ghr * 2) + int'(ex_taken)) % N;
        end
    end

    always @(negedge clk) begin
        automatic bit res = ex_valid && is_br(ex_inst);
        automatic bit mis = res && (ex_pred != ex_taken);
        automatic int ix = m_idx(if_pc);
        chk("m_if_idx", int'(if_idx), ix);
        chk("m_if_pred", int'(if_pred), int'(is_br(if_inst) && m_cnt[ix] >= 2));
        chk("m_redirect", int'(redirect), int'(mis));
        chk("m_flush", int'(flush), res ? (mis ? 3 : 0) : int'(flush_in));
        if (!res || mis) chk("m_redirect_tgt", int'(redirect_tgt), int'(mis && ex_taken));
        chk("m_mispredict_cnt", int'(mispredict_cnt), m_mis);
    end

    task automatic drv(input logic [31:0] pc, input logic [31:0] inst, input logic ev,
                       input logic [31:0] einst, input int eidx, input logic ep,
                       input logic et, input logic [1:0] fin);
        if_pc = pc; if_inst = inst; ex_valid = ev; ex_inst = einst;
        ex_idx = IW'(eidx); ex_pred = ep; ex_taken = et; flush_in = fin;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        drv(pc, BEQ, 0, ADD, 0, 0, 0, 2'b00);
        #1;
    endtask

    initial begin
        drv(32'h100, BEQ, 0, ADD, 0, 0, 0, 2'b10);
        #1 rst_n = 0;
        #1;
        chk("rst_redirect", int'(redirect), 0);
        chk("rst_flush", int'(flush), 2);
        chk("rst_if_pred", int'(if_pred), 0);
        cyc();
        rst_n = 1;
`ifndef BP_GSHARE_EN
        fetch(32'h100);
        chk("fetch_idx", int'(if_idx), 0);
        chk("fetch_pred", int'(if_pred), 0);
        chk("fetch_cnt", int'(mispredict_cnt), 0);
        cyc();
        drv(32'h100, BEQ, 1, BEQ, 0, 0, 1, 2'b01);
        #1;
        chk("mis_redirect", int'(redirect), 1);
        chk("mis_tgt", int'(redirect_tgt), 1);
        chk("mis_flush", int'(flush), 3);
        chk("mis_nobypass_pred", int'(if_pred), 0);
        cyc();
        fetch(32'h100);
        chk("trained_pred", int'(if_pred), 1);
        chk("trained_cnt", int'(mispredict_cnt), 1);
        cyc();
        begin
            automatic logic [9:0] tk   = 10'b11_0000_1111;
            automatic logic [9:0] pred = 10'b10_0001_1111;
            for (int i = 0; i < 10; i++) begin
                drv(32'h14, BEQ, 1, BEQ, 5, 0, tk[i], 2'b00);
                cyc();
                fetch(32'h14);
                chk($sformatf("sat_pred%0d", i), int'(if_pred), int'(pred[i]));
            end
        end
        chk("sat_cnt", int'(mispredict_cnt), 7);
        cyc();
        drv(32'h14, BEQ, 1, ADD, 5, 0, 1, 2'b11);
        #1;
        chk("nonbr_flush", int'(flush), 3);
        chk("nonbr_redirect", int'(redirect), 0);
        chk("nonbr_tgt", int'(redirect_tgt), 0);
        cyc();
        fetch(32'h14);
        chk("nonbr_pred", int'(if_pred), 1);
        chk("nonbr_cnt", int'(mispredict_cnt), 7);
        cyc();
        drv(32'h1C, BEQ, 0, BEQ, 7, 0, 1, 2'b01);
        #1;
        chk("inv_flush", int'(flush), 1);
        chk("inv_redirect", int'(redirect), 0);
        cyc();
        fetch(32'h1C);
        chk("inv_pred", int'(if_pred), 0);
        chk("inv_cnt", int'(mispredict_cnt), 7);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drv(32'h24, BEQ, 1, BEQ, 9, 0, 1, 2'b00);
            cyc();
        end
        fetch(32'h24);
        chk("cnt_sat", int'(mispredict_cnt), 15);
        chk("idx9_pred", int'(if_pred), 1);
        fetch(32'h3FC);
        chk("idx_top", int'(if_idx), 63);
        fetch(32'h400);
        chk("idx_wrap", int'(if_idx), 0);
        cyc();
        fetch(32'h24);
        rst_n = 0;
        #1;
        chk("mid_rst_pred", int'(if_pred), 0);
        chk("mid_rst_cnt", int'(mispredict_cnt), 0);
        rst_n = 1;
        cyc();
        drv(32'h24, BEQ, 1, BEQ, 9, 0, 1, 2'b00);
        cyc();
        fetch(32'h24);
        chk("post_rst_pred", int'(if_pred), 1);
        chk("post_rst_cnt", int'(mispredict_cnt), 1);
        cyc();
`else
        drv(32'h0, ADD, 1, BEQ, 1, 0, 1, 2'b00);
        cyc();
        drv(32'h0, ADD, 1, BEQ, 2, 0, 1, 2'b00);
        cyc();
        drv(32'h0, ADD, 1, BEQ, 3, 1, 0, 2'b00);
        cyc();
        fetch(32'h100);
        chk("gshare_idx", int'(if_idx), 6);
        chk("gshare_cnt", int'(mispredict_cnt), 3);
        fetch(32'h104);
        chk("gshare_idx2", int'(if_idx), 7);
        cyc();
        fetch(32'h100);
        rst_n = 0;
        #1;
        chk("gshare_rst_idx", int'(if_idx), 0);
        rst_n = 1;
        cyc();
`endif
        drv(32'h0, ADD, 0, ADD, 0, 0, 0, 2'b00);
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
